instr_prefetch_queue: RTL
=========================

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, 4, queue entries and max outstanding memory requests; power of two, 2..16.
REQ-002 Parameter RESET_PC, 64'h2000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  one-cycle pulse: flush queue, restart fetch at redirect_pc.
REQ-006 redirect_pc  input  64  new fetch address, sampled when redirect_valid=1.
REQ-007 fetch_hold  input  1  when 1, no new memory requests issue; queue and in-flight responses unaffected.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request when both valid and ready are 1.
REQ-010 imem_req_addr  output  64  byte address of requested 32-bit word.
REQ-011 imem_resp_valid  input  1  in-order response strobe, one per accepted request.
REQ-012 imem_resp_data  input  32  instruction word, little-endian as stored in memory.
REQ-013 out_valid  output  1  head entry valid for decode stage.
REQ-014 out_ready  input  1  decode stage consumes head when out_valid and out_ready are 1.
REQ-015 out_instr  output  32  head instruction word.
REQ-016 out_pc  output  64  address the head word was fetched from.

Function
REQ-017 States SHALL be S_RUN and S_FLUSH; S_RUN issues requests, S_FLUSH discards stale responses and issues none.
REQ-018 Counters: fetch_pc (64b), count (queue occupancy, 0..DEPTH), outstanding (accepted requests without response, 0..DEPTH), drop_cnt (stale responses still to discard).
REQ-019 imem_req_valid SHALL be 1 iff state=S_RUN, fetch_hold=0, redirect_valid=0, and count+outstanding<DEPTH.
REQ-020 imem_req_addr SHALL equal fetch_pc; on each accepted request fetch_pc increments by 4, modulo 2^64 (wraps to 0, no error).
REQ-021 Each request SHALL record its address in a PC FIFO so the matching response is tagged with the correct out_pc.
REQ-022 In S_RUN a response SHALL be written to queue tail at the edge it is sampled; out_valid rises the next cycle (1-cycle resp-to-out latency).
REQ-023 out_instr/out_pc SHALL come from registered head storage; out_valid = (count!=0).
REQ-024 Simultaneous enqueue and dequeue SHALL keep count unchanged; enqueue when full cannot occur by REQ-019 credit rule.
REQ-025 Redirect (highest priority): count<=0, fetch_pc<=redirect_pc, drop_cnt<=outstanding-imem_resp_valid, outstanding likewise; same-cycle response and same-cycle out handshake are discarded.
REQ-026 After redirect: state<=S_FLUSH if new drop_cnt!=0, else S_RUN.
REQ-027 In S_FLUSH each response decrements drop_cnt and outstanding and is not enqueued; on reaching 0, state<=S_RUN next cycle.
REQ-028 Redirect during S_FLUSH SHALL reload fetch_pc and keep discarding all still-outstanding responses.
REQ-029 Response with outstanding=0 is a protocol violation; it SHALL be ignored (no enqueue, counters unchanged).
REQ-030 fetch_hold SHALL not block response enqueue, dequeue, or redirect.

Reset
REQ-031 On reset=1 at an edge: state<=S_RUN, fetch_pc<=RESET_PC, count, outstanding, drop_cnt<=0; in-flight responses are not tracked.
REQ-032 Reset values: imem_req_valid=0 during reset cycle, out_valid=0, out_instr=0, out_pc=0; imem_req_addr=RESET_PC.
REQ-033 Reset overrides redirect_valid and all other inputs in the same cycle.

Verification
REQ-034 Reset, req_ready=1, resp 1 cycle later with data 0x11,0x22,... -> requests at 0x2000,0x2004,...; out pairs (0x2000,0x11),(0x2004,0x22) in order.
REQ-035 out_ready=0, DEPTH=4, memory always ready -> exactly 4 requests issued (0x2000..0x200C), then imem_req_valid=0; out_valid held with 0x2000 head.
REQ-036 3 requests outstanding, redirect to 0x3000 -> drop_cnt=3, next 3 responses discarded, first enqueued entry has out_pc=0x3000.
REQ-037 Redirect same cycle as response and out handshake -> queue empty next cycle, that response dropped, drop_cnt=outstanding-1.
REQ-038 redirect_pc=64'hFFFF_FFFF_FFFF_FFFC -> request at that address then 0x0000; fetch_hold=1 for 5 cycles -> no requests, pending responses still enqueued.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - instruction prefetch queue with credit-limited fetch and redirect flush
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        fetch_hold,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   pc_wr_q, pc_wr_d;
    logic [PW-1:0]   pc_rd_q, pc_rd_d;

    // Decoded-queue payload and the address FIFO that tags each in-flight request.
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     instr_mem_d [DEPTH];
    logic [63:0]     pc_mem_q    [DEPTH];
    logic [63:0]     pc_mem_d    [DEPTH];
    logic [63:0]     req_pc_q    [DEPTH];
    logic [63:0]     req_pc_d    [DEPTH];

    logic            req_fire;
    logic            resp_ok;
    logic            enq;
    logic            deq;
    logic [CW:0]     occupancy;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect decides from the new drop count, flush exits once it drains
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (drop_cnt_d != '0) ? S_FLUSH : S_RUN;
        end else if (state_q == S_FLUSH && drop_cnt_d == '0) begin
            state_d = S_RUN;
        end
    end

    // Outputs: request credit gate and registered head entry
    always_comb begin
        occupancy      = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_valid = !reset && (state_q == S_RUN) && !fetch_hold && !redirect_valid
                         && (occupancy < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        out_valid      = (count_q != '0);
        out_instr      = instr_mem_q[head_q];
        out_pc         = pc_mem_q[head_q];
    end

    // Datapath next values; a response with nothing outstanding is ignored entirely
    always_comb begin
        req_fire      = imem_req_valid && imem_req_ready;
        resp_ok       = imem_resp_valid && (outstanding_q != '0);
        enq           = resp_ok && (state_q == S_RUN) && !redirect_valid;
        deq           = out_valid && out_ready && !redirect_valid;

        fetch_pc_d    = fetch_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        head_d        = head_q;
        tail_d        = tail_q;
        pc_wr_d       = pc_wr_q;
        pc_rd_d       = pc_rd_q;
        instr_mem_d   = instr_mem_q;
        pc_mem_d      = pc_mem_q;
        req_pc_d      = req_pc_q;

        if (req_fire) begin
            req_pc_d[pc_wr_q] = fetch_pc_q;
            pc_wr_d           = pc_wr_q + PW'(1);
            fetch_pc_d        = fetch_pc_q + 64'd4;
        end

        // Every counted response retires its address tag, stale or not.
        if (resp_ok) begin
            pc_rd_d = pc_rd_q + PW'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc;
            count_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            outstanding_d = outstanding_q - CW'(resp_ok);
            drop_cnt_d    = outstanding_q - CW'(resp_ok);
        end else begin
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
            if (state_q == S_FLUSH) begin
                drop_cnt_d = drop_cnt_q - CW'(resp_ok);
            end
            if (enq) begin
                instr_mem_d[tail_q] = imem_resp_data;
                pc_mem_d[tail_q]    = req_pc_q[pc_rd_q];
                tail_d              = tail_q + PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            pc_wr_q       <= '0;
            pc_rd_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
                req_pc_q[i]    <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            pc_wr_q       <= pc_wr_d;
            pc_rd_q       <= pc_rd_d;
            instr_mem_q   <= instr_mem_d;
            pc_mem_q      <= pc_mem_d;
            req_pc_q      <= req_pc_d;
        end
    end

endmodule
